// File: rtl/glitch_pkg.sv
// Shared types, default widths and helpers for the clock-glitch sequencer.
package glitch_pkg;

    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned PULSE_W_DEF = 8;
    localparam int unsigned DATA_W_DEF  = 5;

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StDelay,
        StGlitch,
        StGap
    } glitch_state_t;

    // A programmed length of 0 behaves as 1; counter widths up to 32 bits.
    function automatic logic [31:0] clamp_min1(input logic [31:0] x);
        return (x == 32'd0) ? 32'd1 : x;
    endfunction

endpackage

// File: rtl/glitch_fault_mon.sv
// Result comparator: saturating mismatch counter and sticky flag.
// With GLITCH_FAULT_LOG_EN defined, also logs window index and result of the first mismatch.
module glitch_fault_mon #(
    parameter int unsigned CNT_W  = 16,
`ifdef GLITCH_FAULT_LOG_EN
    parameter int unsigned PULSE_W = 8,
`endif
    parameter int unsigned DATA_W = 5
) (
    input  logic               clk_in1,
    input  logic               rst,
    input  logic               clear,
    input  logic               res_valid,
    input  logic [DATA_W-1:0]  res_dut,
    input  logic [DATA_W-1:0]  res_gold,
`ifdef GLITCH_FAULT_LOG_EN
    input  logic [PULSE_W-1:0] pulse_idx,
    output logic [PULSE_W-1:0] first_fault_idx,
    output logic [DATA_W-1:0]  first_fault_dut,
`endif
    output logic [CNT_W-1:0]   fault_cnt,
    output logic               fault_flag
);

    logic             mismatch;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             flag_d, flag_q;

    assign mismatch = res_valid && (res_dut != res_gold);

    // Clear (an accepted arm) wins over a same-cycle mismatch.
    always_comb begin
        cnt_d  = cnt_q;
        flag_d = flag_q;
        if (clear) begin
            cnt_d  = '0;
            flag_d = 1'b0;
        end else if (mismatch) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in1) begin
        if (rst) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign fault_cnt  = cnt_q;
    assign fault_flag = flag_q;

`ifdef GLITCH_FAULT_LOG_EN
    logic [PULSE_W-1:0] log_idx_d, log_idx_q;
    logic [DATA_W-1:0]  log_dut_d, log_dut_q;

    // flag_q low means no mismatch has been seen since the last clear.
    always_comb begin
        log_idx_d = log_idx_q;
        log_dut_d = log_dut_q;
        if (clear) begin
            log_idx_d = '0;
            log_dut_d = '0;
        end else if (mismatch && !flag_q) begin
            log_idx_d = pulse_idx;
            log_dut_d = res_dut;
        end
    end

    always_ff @(posedge clk_in1) begin
        if (rst) begin
            log_idx_q <= '0;
            log_dut_q <= '0;
        end else begin
            log_idx_q <= log_idx_d;
            log_dut_q <= log_dut_d;
        end
    end

    assign first_fault_idx = log_idx_q;
    assign first_fault_dut = log_dut_q;
`endif

endmodule

// File: rtl/glitch_sequencer.sv
// Programmable clock-glitch sequencer: trigger -> delay -> N glitch windows, plus fault monitor.
// Optional GLITCH_FAULT_LOG_EN adds first-fault logging outputs.
module glitch_sequencer
    import glitch_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned PULSE_W = PULSE_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF
) (
    input  logic               clk_in1,
    input  logic               rst,
    input  logic               arm,
    input  logic               abort,
    input  logic               trigger,
    input  logic [CNT_W-1:0]   cfg_delay,
    input  logic [CNT_W-1:0]   cfg_width,
    input  logic [CNT_W-1:0]   cfg_gap,
    input  logic [PULSE_W-1:0] cfg_pulses,
    output logic               glitch_sel,
    output logic               busy,
    output logic               done,
    output logic [PULSE_W-1:0] pulse_idx,
    input  logic               res_valid,
    input  logic [DATA_W-1:0]  res_dut,
    input  logic [DATA_W-1:0]  res_gold,
`ifdef GLITCH_FAULT_LOG_EN
    output logic [PULSE_W-1:0] first_fault_idx,
    output logic [DATA_W-1:0]  first_fault_dut,
`endif
    output logic [CNT_W-1:0]   fault_cnt,
    output logic               fault_flag
);

    glitch_state_t      state_d, state_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic [PULSE_W-1:0] idx_d, idx_q;
    logic [CNT_W-1:0]   delay_q, width_q, gap_q;
    logic [PULSE_W-1:0] pulses_q;
    logic               trig_q;
    logic               sel_q, busy_q, done_d, done_q;
    logic               cfg_load;
    logic               trig_edge;
    logic               last_win;
    logic [CNT_W-1:0]   width_m1, gap_m1;

    assign trig_edge = trigger && !trig_q;
    assign last_win  = (idx_q == pulses_q - PULSE_W'(1));
    assign width_m1  = CNT_W'(clamp_min1(32'(width_q)) - 32'd1);
    assign gap_m1    = CNT_W'(clamp_min1(32'(gap_q)) - 32'd1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        cfg_load = 1'b0;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (arm) begin
                        cfg_load = 1'b1;
                        idx_d    = '0;
                        if (cfg_pulses == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = StArmed;
                        end
                    end
                end
                StArmed: begin
                    if (trig_edge) begin
                        state_d = StDelay;
                        cnt_d   = delay_q;
                        idx_d   = '0;
                    end
                end
                StDelay: begin
                    if (cnt_q == '0) begin
                        state_d = StGlitch;
                        cnt_d   = width_m1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                StGlitch: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (last_win) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StGap;
                        cnt_d   = gap_m1;
                    end
                end
                StGap: begin
                    if (cnt_q == '0) begin
                        state_d = StGlitch;
                        cnt_d   = width_m1;
                        idx_d   = idx_q + PULSE_W'(1);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_in1) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            trig_q  <= 1'b1;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            trig_q  <= trigger;
            sel_q   <= (state_d == StGlitch);
            busy_q  <= (state_d != StIdle);
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk_in1) begin
        if (rst) begin
            delay_q  <= '0;
            width_q  <= '0;
            gap_q    <= '0;
            pulses_q <= '0;
        end else if (cfg_load) begin
            delay_q  <= cfg_delay;
            width_q  <= cfg_width;
            gap_q    <= cfg_gap;
            pulses_q <= cfg_pulses;
        end
    end

    assign glitch_sel = sel_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pulse_idx  = idx_q;

    glitch_fault_mon #(
        .CNT_W   (CNT_W),
`ifdef GLITCH_FAULT_LOG_EN
        .PULSE_W (PULSE_W),
`endif
        .DATA_W  (DATA_W)
    ) u_fault_mon (
        .clk_in1         (clk_in1),
        .rst             (rst),
        .clear           (cfg_load),
        .res_valid       (res_valid),
        .res_dut         (res_dut),
        .res_gold        (res_gold),
`ifdef GLITCH_FAULT_LOG_EN
        .pulse_idx       (idx_q),
        .first_fault_idx (first_fault_idx),
        .first_fault_dut (first_fault_dut),
`endif
        .fault_cnt       (fault_cnt),
        .fault_flag      (fault_flag)
    );

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer; a second instance with CNT_W=2 covers saturation.
// Build with GLITCH_FAULT_LOG_EN defined to also cover the first-fault log.
module tb_glitch_sequencer;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned PULSE_W = 8;
    localparam int unsigned DATA_W  = 5;

    logic               clk_in1 = 1'b0;
    logic               rst, arm, abort, trigger;
    logic [CNT_W-1:0]   cfg_delay, cfg_width, cfg_gap;
    logic [PULSE_W-1:0] cfg_pulses;
    logic               res_valid;
    logic [DATA_W-1:0]  res_dut, res_gold;

    logic               glitch_sel, busy, done, fault_flag;
    logic [PULSE_W-1:0] pulse_idx;
    logic [CNT_W-1:0]   fault_cnt;

    logic               s_glitch_sel, s_busy, s_done, s_fault_flag;
    logic [PULSE_W-1:0] s_pulse_idx;
    logic [1:0]         s_fault_cnt;

`ifdef GLITCH_FAULT_LOG_EN
    logic [PULSE_W-1:0] first_fault_idx, s_first_fault_idx;
    logic [DATA_W-1:0]  first_fault_dut, s_first_fault_dut;
`endif

    int n_vec = 0;
    int n_err = 0;
    int edge_n = 0;

    always #5 clk_in1 = ~clk_in1;

    glitch_sequencer #(
        .CNT_W   (CNT_W),
        .PULSE_W (PULSE_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk_in1         (clk_in1),
        .rst             (rst),
        .arm             (arm),
        .abort           (abort),
        .trigger         (trigger),
        .cfg_delay       (cfg_delay),
        .cfg_width       (cfg_width),
        .cfg_gap         (cfg_gap),
        .cfg_pulses      (cfg_pulses),
        .glitch_sel      (glitch_sel),
        .busy            (busy),
        .done            (done),
        .pulse_idx       (pulse_idx),
        .res_valid       (res_valid),
        .res_dut         (res_dut),
        .res_gold        (res_gold),
`ifdef GLITCH_FAULT_LOG_EN
        .first_fault_idx (first_fault_idx),
        .first_fault_dut (first_fault_dut),
`endif
        .fault_cnt       (fault_cnt),
        .fault_flag      (fault_flag)
    );

    glitch_sequencer #(
        .CNT_W   (2),
        .PULSE_W (PULSE_W),
        .DATA_W  (DATA_W)
    ) dut_small (
        .clk_in1         (clk_in1),
        .rst             (rst),
        .arm             (arm),
        .abort           (abort),
        .trigger         (trigger),
        .cfg_delay       (cfg_delay[1:0]),
        .cfg_width       (cfg_width[1:0]),
        .cfg_gap         (cfg_gap[1:0]),
        .cfg_pulses      (cfg_pulses),
        .glitch_sel      (s_glitch_sel),
        .busy            (s_busy),
        .done            (s_done),
        .pulse_idx       (s_pulse_idx),
        .res_valid       (res_valid),
        .res_dut         (res_dut),
        .res_gold        (res_gold),
`ifdef GLITCH_FAULT_LOG_EN
        .first_fault_idx (s_first_fault_idx),
        .first_fault_dut (s_first_fault_dut),
`endif
        .fault_cnt       (s_fault_cnt),
        .fault_flag      (s_fault_flag)
    );

    task automatic tick();
        @(posedge clk_in1);
        #1;
        edge_n++;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic set_cfg(input int d, input int w, input int g, input int n);
        cfg_delay  = d[CNT_W-1:0];
        cfg_width  = w[CNT_W-1:0];
        cfg_gap    = g[CNT_W-1:0];
        cfg_pulses = n[PULSE_W-1:0];
    endtask

    task automatic strobe(input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] g);
        res_dut   = d;
        res_gold  = g;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
    endtask

    // Arm at edge 0, raise trigger so it is sampled at t_edge, then check every edge to the end.
    task automatic run_seq(input string tag, input int d, input int w, input int g, input int n,
                           input int t_edge, input logic [63:0] sel_mask, input int done_edge,
                           input int idx_end);
        set_cfg(d, w, g, n);
        trigger = 1'b0;
        arm     = 1'b1;
        tick();
        arm     = 1'b0;
        edge_n  = 0;
        check_eq({tag, "_armed_busy"}, 32'(busy), 32'd1);
        while (edge_n < t_edge - 1) tick();
        trigger = 1'b1;
        tick();
        for (int e = t_edge; e <= done_edge + 1; e++) begin
            check_eq({tag, "_sel"}, 32'(glitch_sel), 32'(sel_mask[e]));
            check_eq({tag, "_done"}, 32'(done), 32'(e == done_edge));
            check_eq({tag, "_busy"}, 32'(busy), 32'(e < done_edge));
            if (e <= done_edge) tick();
        end
        check_eq({tag, "_idx"}, 32'(pulse_idx), 32'(idx_end));
        trigger = 1'b0;
        tick();
    endtask

    logic [63:0] mask_basic, mask_clamp;

    initial begin
        rst = 1'b1; arm = 1'b0; abort = 1'b0; trigger = 1'b0;
        res_valid = 1'b0; res_dut = '0; res_gold = '0;
        set_cfg(0, 0, 0, 0);
        mask_basic = '0;
        mask_basic[14] = 1'b1; mask_basic[15] = 1'b1;
        mask_basic[20] = 1'b1; mask_basic[21] = 1'b1;
        mask_basic[26] = 1'b1; mask_basic[27] = 1'b1;
        mask_clamp = '0;
        mask_clamp[6] = 1'b1; mask_clamp[8] = 1'b1;

        tick(); tick();
        rst = 1'b0;
        tick();
        check_eq("rst_sel", 32'(glitch_sel), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_idx", 32'(pulse_idx), 32'd0);
        check_eq("rst_fcnt", 32'(fault_cnt), 32'd0);
        check_eq("rst_fflag", 32'(fault_flag), 32'd0);

        run_seq("basic", 3, 2, 4, 3, 10, mask_basic, 28, 2);
        run_seq("clamp", 0, 0, 0, 2, 5, mask_clamp, 9, 1);

        // Zero windows: done right after arm, never busy, trigger has no effect.
        set_cfg(1, 1, 1, 0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check_eq("n0_done", 32'(done), 32'd1);
        check_eq("n0_busy", 32'(busy), 32'd0);
        check_eq("n0_idx", 32'(pulse_idx), 32'd0);
        tick();
        check_eq("n0_done_off", 32'(done), 32'd0);
        trigger = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("n0_sel", 32'(glitch_sel), 32'd0);
            check_eq("n0_busy2", 32'(busy), 32'd0);
        end
        trigger = 1'b0;
        tick();

        // Abort during the third high cycle of a 10-cycle window.
        set_cfg(0, 10, 1, 1);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        trigger = 1'b1;
        tick();
        tick(); tick(); tick();
        check_eq("abort_sel_pre", 32'(glitch_sel), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_sel", 32'(glitch_sel), 32'd0);
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        tick();
        check_eq("abort_done2", 32'(done), 32'd0);
        check_eq("abort_sel2", 32'(glitch_sel), 32'd0);
        trigger = 1'b0;
        tick();
        run_seq("rerun", 3, 2, 4, 3, 10, mask_basic, 28, 2);

        // Trigger held high through reset and arm must not start the sequence.
        trigger = 1'b1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        check_eq("hold_busy_rst", 32'(busy), 32'd0);
        set_cfg(0, 1, 1, 1);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("hold_sel", 32'(glitch_sel), 32'd0);
            check_eq("hold_armed", 32'(busy), 32'd1);
        end
        trigger = 1'b0;
        tick();
        check_eq("hold_sel_fall", 32'(glitch_sel), 32'd0);
        trigger = 1'b1;
        tick();
        check_eq("hold_sel_t", 32'(glitch_sel), 32'd0);
        tick();
        check_eq("hold_sel_t1", 32'(glitch_sel), 32'd1);
        tick();
        check_eq("hold_sel_t2", 32'(glitch_sel), 32'd0);
        check_eq("hold_done_t2", 32'(done), 32'd1);
        trigger = 1'b0;
        tick();

        // Fault monitor.
        set_cfg(0, 0, 0, 0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        strobe(5'h01, 5'h02);
        strobe(5'h03, 5'h04);
        strobe(5'h07, 5'h07);
        strobe(5'h00, 5'h1f);
        check_eq("flt_cnt3", 32'(fault_cnt), 32'd3);
        check_eq("flt_flag", 32'(fault_flag), 32'd1);
        check_eq("flt_small3", 32'(s_fault_cnt), 32'd3);
        strobe(5'h0a, 5'h0b);
        strobe(5'h10, 5'h11);
        check_eq("flt_cnt5", 32'(fault_cnt), 32'd5);
        check_eq("flt_small_sat", 32'(s_fault_cnt), 32'd3);
        check_eq("flt_small_flag", 32'(s_fault_flag), 32'd1);
        strobe(5'h12, 5'h12);
        check_eq("flt_match_hold", 32'(fault_cnt), 32'd5);
        arm = 1'b1;
        strobe(5'h01, 5'h02);
        arm = 1'b0;
        check_eq("flt_arm_cnt", 32'(fault_cnt), 32'd0);
        check_eq("flt_arm_flag", 32'(fault_flag), 32'd0);
        check_eq("flt_arm_small", 32'(s_fault_cnt), 32'd0);
        tick();

`ifdef GLITCH_FAULT_LOG_EN
        // First mismatch lands while window 1 is active.
        set_cfg(0, 1, 1, 3);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check_eq("log_clr_idx", 32'(first_fault_idx), 32'd0);
        check_eq("log_clr_dut", 32'(first_fault_dut), 32'd0);
        trigger = 1'b1;
        tick();
        tick(); tick(); tick();
        check_eq("log_at_idx1", 32'(pulse_idx), 32'd1);
        strobe(5'h1a, 5'h00);
        strobe(5'h03, 5'h00);
        check_eq("log_idx", 32'(first_fault_idx), 32'd1);
        check_eq("log_dut", 32'(first_fault_dut), 32'h1a);
        check_eq("log_cnt", 32'(fault_cnt), 32'd2);
        repeat (4) tick();
        trigger = 1'b0;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
